// File: rtl/sto_bin_pkg.sv
// Shared stochastic-computing types: FSM state encodings for the
// stream-to-binary counter and the comparator-based bit generator.
package sto_bin_pkg;

  // Stream-to-binary accumulator states
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } sc_bin_state_e;

  // Comparator-based bit generator states (paired front end)
  typedef enum logic [1:0] {
    GEN_IDLE = 2'b00,
    GEN_SEED = 2'b01,
    GEN_RUN  = 2'b10
  } sc_gen_state_e;

  // Window length in enabled cycles for a given counter width
  function automatic int unsigned sc_window_len(input int unsigned width);
    return 32'd1 << width;
  endfunction

endpackage

// File: rtl/sto_bin.sv
// Stochastic bitstream to binary converter: counts ones over a window of
// 2^IWID enabled bits and presents the count with a valid/ready handshake.
module sto_bin
  import sto_bin_pkg::*;
#(
  parameter int IWID = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            iStart,
  input  logic            iEn,
  input  logic            iDbit,
  input  logic            iRdy,
  input  logic            iClrOvf,
  output logic [IWID:0]   oData,
  output logic            oVld,
  output logic            oBusy,
  output logic            oOvf
);

  localparam int OW = IWID + 1;
  localparam logic [IWID-1:0] WIN_LAST = {IWID{1'b1}};

  sc_bin_state_e   state_q, state_d;
  logic [IWID-1:0] win_q,   win_d;
  logic [IWID:0]   ones_q,  ones_d;
  logic [IWID:0]   data_q,  data_d;
  logic            vld_q,   vld_d;
  logic            ovf_q,   ovf_d;
  logic            capture;

  // Next-state logic: window/ones counters, capture, handshake and overflow
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    ones_d  = ones_q;
    data_d  = data_q;
    vld_d   = vld_q;
    ovf_d   = ovf_q;
    capture = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (iStart) begin
          state_d = ST_ACC;
          win_d   = '0;
          ones_d  = '0;
        end
      end
      ST_ACC: begin
        if (iEn && (win_q == WIN_LAST)) begin
          // Last bit of the window: the ones counter is one bit wider than
          // the window counter, so an all-ones window reaches 2^IWID exactly.
          capture = 1'b1;
          data_d  = ones_q + OW'(iDbit);
          win_d   = '0;
          ones_d  = '0;
          state_d = iStart ? ST_ACC : ST_IDLE;
        end else if (iStart) begin
          // Restart before the window completed: discard partial count
          win_d  = '0;
          ones_d = '0;
        end else if (iEn) begin
          win_d  = win_q + IWID'(1);
          ones_d = ones_q + OW'(iDbit);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A fresh capture keeps the result valid even if the old one was taken
    if (capture) begin
      vld_d = 1'b1;
    end else if (vld_q && iRdy) begin
      vld_d = 1'b0;
    end

    // Overwriting an unaccepted result is sticky; setting beats clearing
    if (capture && vld_q && !iRdy) begin
      ovf_d = 1'b1;
    end else if (iClrOvf) begin
      ovf_d = 1'b0;
    end
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      win_q   <= '0;
      ones_q  <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      ones_q  <= ones_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      ovf_q   <= ovf_d;
    end
  end

  assign oData = data_q;
  assign oVld  = vld_q;
  assign oOvf  = ovf_q;
  assign oBusy = (state_q == ST_ACC);

endmodule

// File: tb/tb_sto_bin.sv
// Self-checking bench for sto_bin with IWID=4 (16-bit windows).
module tb_sto_bin;

  localparam int IWID = 4;

  logic          clk;
  logic          rst_n;
  logic          iStart;
  logic          iEn;
  logic          iDbit;
  logic          iRdy;
  logic          iClrOvf;
  logic [IWID:0] oData;
  logic          oVld;
  logic          oBusy;
  logic          oOvf;

  int n_vec = 0;
  int n_err = 0;
  int exp_q[$];

  sto_bin #(.IWID(IWID)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .iStart  (iStart),
    .iEn     (iEn),
    .iDbit   (iDbit),
    .iRdy    (iRdy),
    .iClrOvf (iClrOvf),
    .oData   (oData),
    .oVld    (oVld),
    .oBusy   (oBusy),
    .oOvf    (oOvf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  // Apply one cycle of inputs, then sample 1ns after the rising edge
  task automatic cyc(input logic s, input logic e, input logic d,
                     input logic r, input logic c);
    iStart  = s;
    iEn     = e;
    iDbit   = d;
    iRdy    = r;
    iClrOvf = c;
    @(posedge clk);
    #1;
  endtask

  // Pop the expected result for a capture that just happened
  task automatic pop_exp(output int v, input string tag);
    if (exp_q.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL %s scoreboard: got empty queue want entry", tag);
      v = -1;
    end else begin
      v = exp_q.pop_front();
    end
  endtask

  task automatic test_reset;
    iStart = 0; iEn = 0; iDbit = 0; iRdy = 0; iClrOvf = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({oData, oVld, oBusy, oOvf} !== 8'h00) begin
      n_err++;
      $display("FAIL reset outs: got data=%0d vld=%0b busy=%0b ovf=%0b want all 0",
               oData, oVld, oBusy, oOvf);
    end
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0);
    $display("reset: data=%0d vld=%0b busy=%0b ovf=%0b", oData, oVld, oBusy, oOvf);
  endtask

  task automatic test_all_ones;
    int e;
    cyc(1, 0, 0, 1, 0);
    n_vec++;
    if (oBusy !== 1'b1) begin
      n_err++; $display("FAIL all_ones busy_start: got %0b want 1", oBusy);
    end
    for (int i = 0; i < 16; i++) begin
      if (i == 15) exp_q.push_back(16);
      cyc(0, 1, 1, 1, 0);
    end
    pop_exp(e, "all_ones");
    n_vec++;
    if (oVld !== 1'b1 || oData !== e[IWID:0]) begin
      n_err++; $display("FAIL all_ones result: got vld=%0b data=%0d want vld=1 data=%0d", oVld, oData, e);
    end
    n_vec++;
    if (oBusy !== 1'b0) begin
      n_err++; $display("FAIL all_ones busy_end: got %0b want 0", oBusy);
    end
    cyc(0, 1, 1, 1, 0);
    n_vec++;
    if (oVld !== 1'b0) begin
      n_err++; $display("FAIL all_ones vld_pulse: got %0b want 0", oVld);
    end
    repeat (3) cyc(0, 1, 1, 1, 0);
    n_vec++;
    if (oData !== 5'd16 || oBusy !== 1'b0) begin
      n_err++; $display("FAIL all_ones hold: got data=%0d busy=%0b want data=16 busy=0", oData, oBusy);
    end
    $display("all_ones: data=%0d vld=%0b busy=%0b", oData, oVld, oBusy);
  endtask

  task automatic test_stall;
    int nb, cycles, ones, e;
    bit early;
    logic en, d;
    nb = 0; cycles = 0; ones = 0; early = 0;
    cyc(1, 0, 0, 1, 0);
    while (nb < 16) begin
      en = (cycles % 3) != 2;
      d  = en ? ((nb % 2) == 0) : 1'b1;
      if (en) begin
        ones += int'(d);
        if (nb == 15) exp_q.push_back(ones);
        nb++;
      end
      cyc(0, en, d, 1, 0);
      cycles++;
      if (nb < 16 && oVld) early = 1;
    end
    pop_exp(e, "stall");
    n_vec++;
    if (early) begin
      n_err++; $display("FAIL stall early_vld: got 1 want 0 before last bit");
    end
    n_vec++;
    if (oVld !== 1'b1 || oData !== e[IWID:0]) begin
      n_err++; $display("FAIL stall result: got vld=%0b data=%0d want vld=1 data=%0d", oVld, oData, e);
    end
    n_vec++;
    if (cycles <= 16) begin
      n_err++; $display("FAIL stall latency: got %0d cycles want >16", cycles);
    end
    cyc(0, 0, 0, 1, 0);
    $display("stall: data=%0d cycles=%0d", oData, cycles);
  endtask

  task automatic test_back_to_back;
    int e;
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) exp_q.push_back(0);
      cyc(i == 15, 1, 0, 0, 0);
    end
    pop_exp(e, "b2b_first");
    n_vec++;
    if (oVld !== 1'b1 || oData !== e[IWID:0] || oBusy !== 1'b1 || oOvf !== 1'b0) begin
      n_err++; $display("FAIL b2b_first: got vld=%0b data=%0d busy=%0b ovf=%0b want 1 %0d 1 0",
                        oVld, oData, oBusy, oOvf, e);
    end
    for (int i = 0; i < 16; i++) begin
      if (i == 15) exp_q.push_back(16);
      cyc(0, 1, 1, 0, 0);
    end
    pop_exp(e, "b2b_second");
    n_vec++;
    if (oVld !== 1'b1 || oData !== e[IWID:0] || oOvf !== 1'b1 || oBusy !== 1'b0) begin
      n_err++; $display("FAIL b2b_second: got vld=%0b data=%0d ovf=%0b busy=%0b want 1 %0d 1 0",
                        oVld, oData, oOvf, oBusy, e);
    end
    cyc(0, 0, 0, 0, 1);
    n_vec++;
    if (oOvf !== 1'b0 || oVld !== 1'b1) begin
      n_err++; $display("FAIL b2b_clrovf: got ovf=%0b vld=%0b want ovf=0 vld=1", oOvf, oVld);
    end
    cyc(0, 0, 0, 1, 0);
    n_vec++;
    if (oVld !== 1'b0) begin
      n_err++; $display("FAIL b2b_accept: got vld=%0b want 0", oVld);
    end
    $display("back_to_back: data=%0d ovf=%0b", oData, oOvf);
  endtask

  task automatic test_abort;
    int e;
    cyc(1, 0, 0, 1, 0);
    repeat (10) cyc(0, 1, 1, 1, 0);
    cyc(1, 1, 1, 1, 0);
    n_vec++;
    if (oBusy !== 1'b1 || oVld !== 1'b0) begin
      n_err++; $display("FAIL abort state: got busy=%0b vld=%0b want busy=1 vld=0", oBusy, oVld);
    end
    for (int i = 0; i < 16; i++) begin
      if (i == 15) exp_q.push_back(0);
      cyc(0, 1, 0, 1, 0);
    end
    pop_exp(e, "abort");
    n_vec++;
    if (oVld !== 1'b1 || oData !== e[IWID:0]) begin
      n_err++; $display("FAIL abort result: got vld=%0b data=%0d want vld=1 data=%0d", oVld, oData, e);
    end
    cyc(0, 0, 0, 1, 0);
    $display("abort: data=%0d", oData);
  endtask

  task automatic test_reset_mid;
    int e;
    bit bad;
    // Leave a pending result so reset has something visible to clear
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) exp_q.push_back(16);
      cyc(0, 1, 1, 0, 0);
    end
    pop_exp(e, "rst_pre");
    n_vec++;
    if (oVld !== 1'b1 || oData !== e[IWID:0]) begin
      n_err++; $display("FAIL rst_pre: got vld=%0b data=%0d want vld=1 data=%0d", oVld, oData, e);
    end
    cyc(1, 0, 0, 0, 0);
    repeat (7) cyc(0, 1, 1, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({oData, oVld, oBusy, oOvf} !== 8'h00) begin
      n_err++; $display("FAIL rst_mid async: got data=%0d vld=%0b busy=%0b ovf=%0b want all 0",
                        oData, oVld, oBusy, oOvf);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1, 1, 1, 0);
      if (oVld !== 1'b0 || oBusy !== 1'b0) bad = 1;
    end
    n_vec++;
    if (bad) begin
      n_err++; $display("FAIL rst_ignore: got vld/busy active want idle without iStart");
    end
    cyc(1, 0, 0, 1, 0);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) exp_q.push_back(16);
      cyc(0, 1, 1, 1, 0);
    end
    pop_exp(e, "rst_post");
    n_vec++;
    if (oVld !== 1'b1 || oData !== e[IWID:0]) begin
      n_err++; $display("FAIL rst_post: got vld=%0b data=%0d want vld=1 data=%0d", oVld, oData, e);
    end
    cyc(0, 0, 0, 1, 0);
    $display("reset_mid: data=%0d vld=%0b", oData, oVld);
  endtask

  task automatic test_capture_ready;
    int e;
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) exp_q.push_back(16);
      cyc(0, 1, 1, 0, 0);
    end
    pop_exp(e, "cap_rdy_first");
    n_vec++;
    if (oVld !== 1'b1 || oData !== e[IWID:0]) begin
      n_err++; $display("FAIL cap_rdy_first: got vld=%0b data=%0d want vld=1 data=%0d", oVld, oData, e);
    end
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) exp_q.push_back(5);
      cyc(0, 1, i < 5, i == 15, 0);
    end
    pop_exp(e, "cap_rdy_second");
    n_vec++;
    if (oVld !== 1'b1 || oData !== e[IWID:0] || oOvf !== 1'b0) begin
      n_err++; $display("FAIL cap_rdy_second: got vld=%0b data=%0d ovf=%0b want vld=1 data=%0d ovf=0",
                        oVld, oData, oOvf, e);
    end
    cyc(0, 0, 0, 1, 0);
    n_vec++;
    if (oVld !== 1'b0 || oData !== 5'd5) begin
      n_err++; $display("FAIL cap_rdy_drain: got vld=%0b data=%0d want vld=0 data=5", oVld, oData);
    end
    $display("capture_ready: data=%0d ovf=%0b", oData, oOvf);
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_stall();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_capture_ready();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL scoreboard leftover: got %0d entries want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
